uart_rx_byte: RTL and testbench

- Receive front end between the board RX pin and the ALU command path.
- Synchronises the asynchronous serial line and deserialises 8N1 UART frames into bytes.
- Presents each byte on a single-entry valid/ready output register.
- Runs in the PLL clock domain (30.375 MHz nominal). Reports framing errors and overruns as one-cycle pulses.

---
 rtl/uart_rx_byte.sv | 147 ++++++++++++++
 tb/tb_uart_rx_byte.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit sampling FSM and a
// single-entry valid/ready output register with framing-error and overrun pulses.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 264,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  localparam int unsigned       IDX_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [15:0]       BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]       HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  // Reset asserts asynchronously but is released only on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  // NOTE: sequential state is always updated with non-blocking assignments.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync <= '0;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic [1:0] rx_sync;
  logic       rx_s;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], rx_i};
  end

  assign rx_s = rx_sync[1];

  state_t                 state, state_d;
  logic [15:0]            cnt, cnt_d;
  logic [IDX_W-1:0]       idx, idx_d;
  logic [DATA_BITS-1:0]   shreg, shreg_d;
  logic [DATA_BITS-1:0]   data_d;
  logic                   valid_d, frame_err_d, overrun_d, commit;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      idx         <= idx_d;
      shreg       <= shreg_d;
      data_o      <= data_d;
      valid_o     <= valid_d;
      frame_err_o <= frame_err_d;
      overrun_o   <= overrun_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d     = state;
    cnt_d       = cnt;
    idx_d       = idx;
    shreg_d     = shreg;
    data_d      = data_o;
    valid_d     = valid_o;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    commit      = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          // A high line at mid start bit was only a glitch.
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_d        = '0;
          shreg_d[idx] = rx_s;
          if (idx == IDX_LAST) state_d = STOP;
          else                 idx_d   = idx + IDX_W'(1);
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      BREAK: begin
        // A line held low reports one framing error, then waits for idle.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      if (!valid_o || ready_i) begin
        data_d  = shreg;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_o && ready_i) begin
      valid_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte at 16 clocks per bit: directed vectors,
// multi-cycle corner sequences and randomized frames against a frame-level model.
module tb_uart_rx_byte;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          rx = 1'b1;
  logic          ready = 1'b1;
  logic [DB-1:0] data_o;
  logic          valid_o, frame_err_o, overrun_o;

  uart_rx_byte #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .rx_i       (rx),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: observes outputs 1 time unit after each falling edge.
  int        cyc = 0;
  int        rise_cyc = -1;
  int        valid_cycles = 0, ferr_cycles = 0, ovr_cycles = 0, both_cycles = 0;
  logic      valid_prev = 1'b0;
  logic [7:0] acc_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(negedge clk);
    #1;
    if (valid_o && ready) acc_q.push_back(data_o);
    if (valid_o) valid_cycles++;
    if (frame_err_o) ferr_cycles++;
    if (overrun_o) ovr_cycles++;
    if (frame_err_o && overrun_o) both_cycles++;
    if (valid_o && !valid_prev) rise_cyc = cyc;
    valid_prev = valid_o;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // All line stimulus is applied on falling edges.
  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic check_bytes(input string name);
    check({name, " count"}, acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < acc_q.size()) check($sformatf("%s byte%0d", name, i), acc_q[i], exp_q[i]);
    end
    acc_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         idle;
    logic       exp_valid;
    logic       exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int t0, v0, f0, o0, nerr;
    logic [7:0] d;
    logic       s;
    int         gap;

    vecs[0] = '{8'h00, 1'b1, 0, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 0, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1, 1'b1, 1'b0};
    vecs[3] = '{8'h6E, 1'b0, 1, 1'b0, 1'b1};
    vecs[4] = '{8'h42, 1'b1, 0, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 2, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 1'b0, 2, 1'b0, 1'b1};
    vecs[7] = '{8'h01, 1'b1, 2, 1'b1, 1'b0};

    // Reset values
    repeat (4) @(negedge clk);
    #2;
    check("reset data_o", data_o, 0);
    check("reset valid_o", valid_o, 0);
    check("reset frame_err_o", frame_err_o, 0);
    check("reset overrun_o", overrun_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    idle_bits(2);

    // Single 0xA5: data, one-cycle valid, latency from the falling start edge
    v0 = valid_cycles; f0 = ferr_cycles; o0 = ovr_cycles;
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    idle_bits(2);
    check_bytes("a5");
    check("a5 valid width", valid_cycles - v0, 1);
    // 2 sync stages, detect edge, half bit, 9 further bits to mid stop, 1 commit cycle
    check("a5 latency", rise_cyc - t0, 2 + CPB / 2 + (DB + 1) * CPB + 1);
    check("a5 no errors", (ferr_cycles - f0) + (ovr_cycles - o0), 0);

    // Table-driven vectors (first three back-to-back)
    f0 = ferr_cycles; o0 = ovr_cycles; nerr = 0;
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].data, vecs[i].stop);
      idle_bits(vecs[i].idle);
      if (vecs[i].exp_valid) exp_q.push_back(vecs[i].data);
      if (vecs[i].exp_err) nerr++;
    end
    idle_bits(1);
    check_bytes("table");
    check("table frame errors", ferr_cycles - f0, nerr);
    check("table overruns", ovr_cycles - o0, 0);

    // Short start glitch, then 0x55
    v0 = valid_cycles; f0 = ferr_cycles;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    idle_bits(2);
    check("glitch no valid", valid_cycles - v0, 0);
    check("glitch no frame_err", ferr_cycles - f0, 0);
    send_frame(8'h55, 1'b1);
    exp_q.push_back(8'h55);
    idle_bits(2);
    check_bytes("after glitch");

    // Framing error followed by a long break: exactly one pulse
    v0 = valid_cycles; f0 = ferr_cycles;
    send_frame(8'h81, 1'b0);
    for (int i = 0; i < 40; i++) send_bit(1'b0);
    idle_bits(2);
    check("break one frame_err", ferr_cycles - f0, 1);
    check("break no valid", valid_cycles - v0, 0);
    send_frame(8'h42, 1'b1);
    exp_q.push_back(8'h42);
    idle_bits(2);
    check_bytes("after break");

    // Overrun: consumer stalled across two frames
    ready = 1'b0;
    o0 = ovr_cycles; f0 = ferr_cycles;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle_bits(2);
    #2;
    check("overrun valid held", valid_o, 1);
    check("overrun data kept", data_o, 8'h11);
    check("overrun one pulse", ovr_cycles - o0, 1);
    check("overrun no frame_err", ferr_cycles - f0, 0);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    #2;
    check("drain valid drops", valid_o, 0);
    check("drain data keeps", data_o, 8'h11);
    exp_q.push_back(8'h11);
    check_bytes("drain");

    // Reset in the middle of a frame while a byte is pending
    send_frame(8'h99, 1'b1);
    idle_bits(1);
    #2;
    check("pre-reset valid", valid_o, 1);
    @(negedge clk);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    rst_ni = 1'b0;
    #1;
    check("midreset valid_o", valid_o, 0);
    check("midreset data_o", data_o, 0);
    check("midreset frame_err_o", frame_err_o, 0);
    check("midreset overrun_o", overrun_o, 0);
    repeat (3) @(negedge clk);
    rx = 1'b1;
    rst_ni = 1'b1;
    ready = 1'b1;
    idle_bits(2);
    acc_q.delete();
    v0 = valid_cycles; f0 = ferr_cycles;
    idle_bits(1);
    check("no spurious byte", valid_cycles - v0, 0);
    send_frame(8'h0F, 1'b1);
    exp_q.push_back(8'h0F);
    idle_bits(2);
    check_bytes("after reset");
    check("after reset no frame_err", ferr_cycles - f0, 0);

    // Randomized frames against a frame-level model
    f0 = ferr_cycles; o0 = ovr_cycles; nerr = 0;
    for (int i = 0; i < 30; i++) begin
      d   = 8'($urandom_range(0, 255));
      s   = ($urandom_range(0, 5) != 0);
      gap = $urandom_range(0, 2);
      if (!s && gap == 0) gap = 1;
      send_frame(d, s);
      idle_bits(gap);
      if (s) exp_q.push_back(d);
      else   nerr++;
    end
    idle_bits(2);
    check_bytes("random");
    check("random frame errors", ferr_cycles - f0, nerr);
    check("random overruns", ovr_cycles - o0, 0);

    check("never both pulses", both_cycles, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
